gate_exerciser: RTL and testbench

//   Self-checking stimulus driver for the 2-input logic gates in this project (And_Gate and siblings).
//   It drives x/y into the gate under test, samples its z output and compares it to a parameterised

---
 rtl/gate_test_pkg.sv | 20 ++
 rtl/gate_exerciser.sv | 134 +++++++++++++
 tb/tb_gate_exerciser.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the 2-input gate exerciser.
package gate_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bit idx of each table is the expected z for input vector idx = {x,y}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  localparam int ERR_W = 8;

endpackage

// File: rtl/gate_exerciser.sv
// Sweeps all four {x,y} vectors into a 2-input gate, compares z_i to TRUTH_TABLE, counts mismatches.
// Optional GATE_EXERCISER_STOP_ON_FAIL_EN: end the run at the first mismatch, keeping the failing vector.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold results of the last run
// DRIVE  | register x_o/y_o from vector_idx
// SETTLE | wait SETTLE_CYCLES for the gate output to settle
// CHECK  | compare z_i, advance vector / sweep
// DONE   | one-cycle completion pulse
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         N_PASSES      = 1,
  parameter logic [3:0] TRUTH_TABLE   = TT_AND
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             x_o,
  output logic             y_o,
  input  logic             z_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vector_idx
);

`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [7:0]       PASS_LAST   = 8'(N_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [3:0]       TT          = TRUTH_TABLE;

  state_t           state, state_nx;
  logic             x_nx, y_nx, pass_nx, mismatch;
  logic [ERR_W-1:0] err_nx;
  logic [1:0]       vidx_nx;
  logic [7:0]       pass_cnt, pcnt_nx;
  logic [3:0]       settle_cnt, scnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_o        <= 1'b0;
      y_o        <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vector_idx <= 2'd0;
      pass_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nx;
      x_o        <= x_nx;
      y_o        <= y_nx;
      pass       <= pass_nx;
      err_count  <= err_nx;
      vector_idx <= vidx_nx;
      pass_cnt   <= pcnt_nx;
      settle_cnt <= scnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = x_o;
    y_nx     = y_o;
    pass_nx  = pass;
    err_nx   = err_count;
    vidx_nx  = vector_idx;
    pcnt_nx  = pass_cnt;
    scnt_nx  = settle_cnt;
    mismatch = 1'b0;
    busy     = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    done     = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = DRIVE;
          err_nx   = '0;
          vidx_nx  = 2'd0;
          pcnt_nx  = 8'd0;
          pass_nx  = 1'b0;
        end
      end
      DRIVE: begin
        x_nx = vector_idx[1];
        y_nx = vector_idx[0];
        if (SETTLE_CYCLES == 0) begin
          state_nx = CHECK;
        end else begin
          state_nx = SETTLE;
          scnt_nx  = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_nx = CHECK;
        else                    scnt_nx  = settle_cnt - 4'd1;
      end
      CHECK: begin
        mismatch = (z_i != TT[vector_idx]);
        if (mismatch && (err_count != ERR_MAX)) err_nx = err_count + 8'd1;
        if (STOP_ON_FAIL && mismatch) begin
          // Hold vector_idx and x_o/y_o on the failing vector for debug.
          state_nx = DONE;
          pass_nx  = 1'b0;
        end else begin
          vidx_nx = vector_idx + 2'd1;
          if (vector_idx == 2'd3) begin
            if (pass_cnt == PASS_LAST) begin
              state_nx = DONE;
              pass_nx  = (err_nx == '0);
            end else begin
              pcnt_nx  = pass_cnt + 8'd1;
              state_nx = DRIVE;
            end
          end else begin
            state_nx = DRIVE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: four instances with different parameters, z_i from an AND model
// or tied low/high; honours GATE_EXERCISER_STOP_ON_FAIL_EN in its expected-result model.
module tb_gate_exerciser;
  import gate_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start      [4];
  logic       x_o        [4];
  logic       y_o        [4];
  logic       z_i        [4];
  logic       busy       [4];
  logic       done       [4];
  logic       pass       [4];
  logic [7:0] err_count  [4];
  logic [1:0] vector_idx [4];
  logic [1:0] z_mode     [4];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int err;
    int pass_b;
    int lat;
    int vidx;
    int xy;
  } exp_t;
  exp_t sb[$];

`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  // Instance 0: defaults (AND); 1: N_PASSES=100; 2: SETTLE_CYCLES=0; 3: XOR table.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign z_i[g] = (z_mode[g] == 2'd0) ? (x_o[g] & y_o[g]) : (z_mode[g] == 2'd2);
    gate_exerciser #(
      .SETTLE_CYCLES(g == 2 ? 0 : 2),
      .N_PASSES     (g == 1 ? 100 : 1),
      .TRUTH_TABLE  (g == 3 ? TT_XOR : TT_AND)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .x_o       (x_o[g]),
      .y_o       (y_o[g]),
      .z_i       (z_i[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (err_count[g]),
      .vector_idx(vector_idx[g])
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int g, input logic [1:0] zm, input int s, input int n,
                     input logic [3:0] tt, input int pulse_at);
    exp_t e;
    int   err = 0;
    int   nvec = 0;
    int   lastv = 0;
    bit   stop = 1'b0;
    int   c = 0;
    bit   got = 1'b0;
    for (int p = 0; p < n && !stop; p++) begin
      for (int v = 0; v < 4 && !stop; v++) begin
        logic zv;
        zv    = (zm == 2'd0) ? (v[1] & v[0]) : (zm == 2'd2);
        nvec++;
        lastv = v;
        if (zv != tt[v]) begin
          if (err < 255) err++;
          if (STOP_EN) stop = 1'b1;
        end
      end
    end
    e.err    = err;
    e.pass_b = (err == 0);
    e.lat    = nvec * (s + 2);
    e.vidx   = stop ? lastv : 0;
    e.xy     = lastv;
    sb.push_back(e);

    @(negedge clk);
    z_mode[g] = zm;
    start[g]  = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
    chk("busy_after_start", busy[g], 1);
    chk("pass_cleared", pass[g], 0);
    chk("err_cleared", err_count[g], 0);
    while (c < e.lat + 20) begin
      @(posedge clk);
      #1;
      c++;
      start[g] = (c == pulse_at);
      if (done[g]) begin
        got = 1'b1;
        break;
      end
      if (c >= 2 && ((c - 2) % (s + 2)) == 0)
        chk("xy_seq", int'({x_o[g], y_o[g]}), ((c - 2) / (s + 2)) % 4);
    end
    start[g] = 1'b0;
    chk("done_seen", int'(got), 1);
    e = sb.pop_front();
    chk("latency", c, e.lat);
    chk("err_count", err_count[g], e.err);
    chk("pass", pass[g], e.pass_b);
    chk("vector_idx", vector_idx[g], e.vidx);
    chk("xy_final", int'({x_o[g], y_o[g]}), e.xy);
    chk("busy_in_done", busy[g], 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done[g], 0);
  endtask

  task automatic check_reset(input int g);
    chk("rst_x", x_o[g], 0);
    chk("rst_y", y_o[g], 0);
    chk("rst_busy", busy[g], 0);
    chk("rst_done", done[g], 0);
    chk("rst_pass", pass[g], 0);
    chk("rst_err", err_count[g], 0);
    chk("rst_vidx", vector_idx[g], 0);
  endtask

  task automatic reset_mid_run();
    int ndone = 0;
    @(negedge clk);
    z_mode[0] = 2'd0;
    start[0]  = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    // Edge 9 drives vector 2; edge 10 leaves the FSM in SETTLE for it.
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done[0]) ndone++;
    end
    chk("pre_rst_vidx", vector_idx[0], 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset(0);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done[0]) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      start[g]  = 1'b0;
      z_mode[g] = 2'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) check_reset(g);
    rst = 1'b0;

    run(0, 2'd0, 2, 1,   TT_AND, 0);
    run(0, 2'd1, 2, 1,   TT_AND, 0);
    run(0, 2'd0, 2, 1,   TT_AND, 5);
    run(1, 2'd2, 2, 100, TT_AND, 0);
    run(2, 2'd0, 0, 1,   TT_AND, 3);
    run(3, 2'd0, 2, 1,   TT_XOR, 0);
    reset_mid_run();
    run(0, 2'd2, 2, 1,   TT_AND, 0);
    run(0, 2'd0, 2, 1,   TT_AND, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
